// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and slice helper for the 8-channel demux.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 2;

    // Low bit of channel k inside a flattened k*width bus.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_8_buf_chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : chan_fifo
//  Description : Per-channel FIFO with occupancy count; head forced to 0 when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             not_full,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign not_empty = (r_count != '0);
    assign not_full  = (r_count < FULL_CNT);
    assign count     = r_count;
    assign head_data = not_empty ? r_mem[r_rd_ptr] : '0;

    assign w_do_push = push && not_full;
    assign w_do_pop  = pop && not_empty;

    // Storage needs no reset: an empty channel never exposes it.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux_8_buf.sv
`default_nettype none
// ============================================================================
//  Module      : demux_8_buf
//  Description : Routes one word to one of 8 buffered valid/ready channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_8_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_select,
    input  logic [WIDTH-1:0]          in_data,
    output logic [NUM_CH-1:0]         out_valid,
    input  logic [NUM_CH-1:0]         out_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data,
    output logic [NUM_CH*CNT_W-1:0]   out_count
);

    logic [NUM_CH-1:0] w_not_full;
    logic [NUM_CH-1:0] w_push_en;
    logic              w_accept;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready = w_not_full[in_select];
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_push_en            = '0;
        w_push_en[in_select] = w_accept;
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
            chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clock     (clock),
                .reset_n   (reset_n),
                .push      (w_push_en[k]),
                .push_data (in_data),
                .pop       (out_ready[k]),
                .head_data (out_data[slice_lo(k, WIDTH) +: WIDTH]),
                .not_empty (out_valid[k]),
                .not_full  (w_not_full[k]),
                .count     (out_count[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/demux_8_buf.md
Name: demux_8_buf

Overview:
- Sequential inverse of the 32-bit 8:1 result mux in the single-cycle ALU datapath.
- Takes one 32-bit word plus a 3-bit select and steers it to one of 8 output channels.
- Each channel has a small FIFO and an independent valid/ready handshake.
- Sits between the ALU result bus and downstream consumers (writeback, flags, debug taps) that may stall independently.

Parameters:
- WIDTH, 32, data width of the input word and of each output channel.
- DEPTH, 2, entries per channel FIFO; must be >= 1 (power of 2 not required).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word and select are valid this cycle.
- in_ready  output  1  the selected channel can accept a word this cycle.
- in_select  input  3  destination channel, 0..7 (3'b000 = channel 0).
- in_data  input  WIDTH  word to route.
- out_valid  output  8  bit k: channel k holds at least one word.
- out_ready  input  8  bit k: consumer k takes the head word this cycle.
- out_data  output  8*WIDTH  channel k head word at bits [k*WIDTH +: WIDTH].
- out_count  output  8*2  channel k occupancy (0..DEPTH) at bits [k*2 +: 2]; 2 bits cover DEPTH <= 3.

Behaviour:
- Reset (reset_n low, asynchronous, any cycle including mid-transfer):
  - all FIFOs are emptied; out_valid = 8'h00; out_count = 0.
  - out_data = 0; in_ready reflects the empty state and is 1.
  - contents in flight are discarded.
  - leaving reset takes effect at the first rising edge with reset_n high.
- Push:
  - in_ready = (count[in_select] < DEPTH). Combinational on in_select and registered counts only; never on out_ready.
  - transfer occurs when in_valid && in_ready at a rising edge.
  - the word is written to the tail of channel in_select.
- Latency: a pushed word appears on out_data/out_valid of its channel in the next cycle at the earliest (1-cycle latency). There is no combinational path from in_data to out_data.
- Pop:
  - channel k pops at a rising edge when out_valid[k] && out_ready[k].
  - the next entry (if any) becomes head in the following cycle.
  - out_ready[k] while out_valid[k]=0 is ignored.
- Output data and ordering:
  - out_data for an empty channel is forced to 0.
  - words within one channel leave in arrival order.
  - there is no ordering between different channels.
- Simultaneous push and pop, same channel:
  - not full: both occur and count is unchanged; head advances and the new word goes to the tail.
  - full: in_ready=0 because it does not look at out_ready, so only the pop occurs. The producer retries the next cycle.
  - empty: push only. The word is visible the next cycle, with no bypass.
- Independent channels: pops on any subset of the 8 channels may occur in the same cycle as a push to another channel.
- Holding rule:
  - when in_valid=1 and in_ready=0, the producer holds in_data and in_select stable until accepted.
  - the block does not latch a stalled request.
- in_select is always 0..7, so there is no out-of-range case. This is the counterpart of the mux default arm, which never occurs.
- Wrap-around: read/write pointers wrap modulo DEPTH. Count saturates only by the in_ready rule; no overflow or underflow is possible.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH = 8, SEL_W = 3, CNT_W = 2.
  - a function computing the channel slice offset (k*WIDTH).
- Sub-module chan_fifo (WIDTH, DEPTH):
  - ports: clock, reset_n, push, push_data, pop, head_data, not_empty, not_full, count.
  - instantiated 8 times by a generate loop.
- Top level: decodes in_select into one-hot push enables ANDed with in_valid && in_ready, and muxes not_full[in_select] onto in_ready.

Test Plan:
- Reset check: hold reset_n=0 mid-stream with 2 words in channel 3 -> out_valid=8'h00, out_count all 0, out_data=0, in_ready=1 immediately (async). After release, channel 3 stays empty.
- Routing: push 32'hDEAD0000+k to select k for k=0..7, all out_ready=0 -> next cycle out_valid=8'hFF, channel k slice = 32'hDEAD0000+k, out_count all 1.
- Backpressure: push 32'h11, 32'h22, 32'h33 to channel 5, out_ready=0 -> first two accepted; third sees in_ready=0 and is held. Raise out_ready[5] for one cycle -> 32'h11 pops; next cycle 32'h33 is accepted; order 22, 33 is preserved.
- Full push+pop: channel 2 full (DEPTH=2), in_valid=1 sel=2 with out_ready[2]=1 -> pop only, in_ready=0, count goes 2 to 1. The next cycle's push is accepted and count returns to 2.
- Concurrency: channels 0 and 7 each hold one word; push to channel 4 with out_ready=8'h81 -> channels 0 and 7 drain, channel 4 gains its word, out_valid=8'h10 next cycle.
- Random soak: 10k cycles of random in_valid, select and out_ready against a scoreboard of 8 queues -> no loss, duplication or reorder. in_ready matches count<DEPTH every cycle.
